// File: rtl/spi_peripheral.sv
// SPI peripheral endpoint, mode 3 (CPOL=1, CPHA=1), MSB first.
// SPI_CLK, SPI_EN and SPI_MOSI are oversampled on clk through two-flop
// synchronizers; a third SPI_CLK flop provides edge strobes.
// Transmit bytes come from a one-deep valid/ready holding buffer.
// Build option: define SPI_PERIPH_TRISTATE_EN to float SPI_MISO while idle.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | select inactive, MISO at idle level, bit counter cleared
// SELECTED | select active, waiting for the first SPI_CLK fall of a frame
// SHIFT    | frame in progress, shifting on synced SPI_CLK edges
module spi_peripheral #(
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] IDLE_TX = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_CLK,
    input  logic              SPI_EN,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, SELECTED, SHIFT} state_t;

    state_t             state, state_nx;
    logic               sclk_s1, sclk_s2, sclk_s3;
    logic               en_s1, en_s2;
    logic               mosi_s1, mosi_s2;
    logic [CNT_W-1:0]   shift_cnt, shift_cnt_nx;
    logic [DATA_W-1:0]  tx_shift, tx_shift_nx;
    logic [DATA_W-1:0]  rx_shift, rx_shift_nx;
    logic [DATA_W-1:0]  rx_data_nx;
    logic               rx_valid_nx, tx_underrun_nx;
    logic               miso_q, miso_nx;
    logic [DATA_W-1:0]  buf_data, buf_data_nx;
    logic               buf_full, buf_full_nx;
    logic               sclk_fall, sclk_rise;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DATA_W-1:0]  rx_word;

    assign sclk_fall = sclk_s3 & ~sclk_s2;
    assign sclk_rise = ~sclk_s3 & sclk_s2;
    assign cnt_inc   = shift_cnt + 1'b1;
    assign rx_word   = {rx_shift[DATA_W-2:0], mosi_s2};
    assign tx_ready  = ~buf_full;

`ifdef SPI_PERIPH_TRISTATE_EN
    assign SPI_MISO = (state == IDLE) ? 1'bz : miso_q;
`else
    assign SPI_MISO = miso_q;
`endif

    // Synchronizers; SPI_CLK idles high so its chain resets to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_s3 <= 1'b1;
            en_s1   <= 1'b0;
            en_s2   <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= SPI_CLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            en_s1   <= SPI_EN;
            en_s2   <= en_s1;
            mosi_s1 <= SPI_MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    // State, shift datapath, receive port and holding buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_cnt   <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            miso_q      <= 1'b1;
            buf_data    <= '0;
            buf_full    <= 1'b0;
        end else begin
            state       <= state_nx;
            shift_cnt   <= shift_cnt_nx;
            tx_shift    <= tx_shift_nx;
            rx_shift    <= rx_shift_nx;
            rx_data     <= rx_data_nx;
            rx_valid    <= rx_valid_nx;
            tx_underrun <= tx_underrun_nx;
            miso_q      <= miso_nx;
            buf_data    <= buf_data_nx;
            buf_full    <= buf_full_nx;
        end
    end

    // Next-state and datapath updates driven by the synced edge strobes.
    always_comb begin
        state_nx       = state;
        shift_cnt_nx   = shift_cnt;
        tx_shift_nx    = tx_shift;
        rx_shift_nx    = rx_shift;
        rx_data_nx     = rx_data;
        rx_valid_nx    = 1'b0;
        tx_underrun_nx = 1'b0;
        miso_nx        = miso_q;
        buf_data_nx    = buf_data;
        buf_full_nx    = buf_full;

        if (!en_s2) begin
            // Deselect aborts any partial frame; a byte already loaded is dropped.
            state_nx     = IDLE;
            shift_cnt_nx = '0;
            miso_nx      = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    shift_cnt_nx = '0;
                    miso_nx      = 1'b1;
                    state_nx     = SELECTED;
                end
                SELECTED: begin
                    if (sclk_fall) begin
                        if (buf_full) begin
                            tx_shift_nx = buf_data;
                            miso_nx     = buf_data[DATA_W-1];
                            buf_full_nx = 1'b0;
                        end else begin
                            tx_shift_nx    = IDLE_TX;
                            miso_nx        = IDLE_TX[DATA_W-1];
                            tx_underrun_nx = 1'b1;
                        end
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_nx  = rx_word;
                        shift_cnt_nx = cnt_inc;
                        if (cnt_inc == CNT_W'(DATA_W)) begin
                            rx_data_nx   = rx_word;
                            rx_valid_nx  = 1'b1;
                            shift_cnt_nx = '0;
                            state_nx     = SELECTED;
                        end
                    end else if (sclk_fall && shift_cnt != '0) begin
                        tx_shift_nx = tx_shift << 1;
                        miso_nx     = tx_shift[DATA_W-2];
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        // A write in the same cycle as a frame-start load lands for the next frame.
        if (tx_valid && !buf_full) begin
            buf_data_nx = tx_data;
            buf_full_nx = 1'b1;
        end
    end

endmodule
